// File: rtl/stall_pipe_ctrl.sv
// stall_pipe_ctrl
//   Consumer side of the D-stage stall interface in the 5-stage MIPS pipeline.
//   A pause request from the hazard detector freezes PC and the F/D register
//   and injects a NOP bubble into the D/E register. The block also keeps
//   saturating stall statistics for performance debug.
//
//   State table
//     RUN   | no stall was applied on the previous edge
//     STALL | the previous edge applied a stall (the episode is already counted)
//
// Ports
//   clk, reset                 clock; asynchronous active-high reset
//   pause                      stall request for the instruction in D
//   IR_F, PC_F                 fetched instruction and its PC
//   RD1_D, RD2_D, EXT_D        D-stage operands and extended immediate
//   PC_en                      PC write enable, combinational from pause
//   IR_D, PC_D                 F/D pipeline register
//   IR_E, PC_E, RS_E, RT_E,
//   EXT_E, bubble_E            D/E pipeline register and bubble marker
//   stall_cycles, stall_events saturating stall statistics
module stall_pipe_ctrl #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] NOP      = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pause,
  input  logic [31:0]      IR_F,
  input  logic [31:0]      PC_F,
  input  logic [31:0]      RD1_D,
  input  logic [31:0]      RD2_D,
  input  logic [31:0]      EXT_D,
  output logic             PC_en,
  output logic [31:0]      IR_D,
  output logic [31:0]      PC_D,
  output logic [31:0]      IR_E,
  output logic [31:0]      PC_E,
  output logic [31:0]      RS_E,
  output logic [31:0]      RT_E,
  output logic [31:0]      EXT_E,
  output logic             bubble_E,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] stall_events
);

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state_q, state_d;
  logic   stall;
  logic   event_inc;

  // Only a clean 1 stalls; an unknown request must never freeze the pipe.
  assign stall = (pause === 1'b1);
  assign PC_en = ~stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    event_inc = 1'b0;
    case (state_q)
      RUN: begin
        if (stall) begin
          state_d   = STALL;
          event_inc = 1'b1;
        end
      end
      STALL: begin
        if (!stall) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      IR_D <= NOP;
      PC_D <= PC_RESET;
    end else if (!stall) begin
      IR_D <= IR_F;
      PC_D <= PC_F;
    end
  end

  // PC_E follows PC_D even for a bubble so the bubble carries a valid PC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      IR_E     <= NOP;
      PC_E     <= PC_RESET;
      RS_E     <= '0;
      RT_E     <= '0;
      EXT_E    <= '0;
      bubble_E <= 1'b0;
    end else if (stall) begin
      IR_E     <= NOP;
      PC_E     <= PC_D;
      RS_E     <= '0;
      RT_E     <= '0;
      EXT_E    <= '0;
      bubble_E <= 1'b1;
    end else begin
      IR_E     <= IR_D;
      PC_E     <= PC_D;
      RS_E     <= RD1_D;
      RT_E     <= RD2_D;
      EXT_E    <= EXT_D;
      bubble_E <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
      stall_events <= '0;
    end else begin
      if (stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_ONE;
      if (event_inc && (stall_events != '1))
        stall_events <= stall_events + CNT_ONE;
    end
  end

endmodule
